regfile_ctrl: RTL and testbench

- Access controller for the 32-entry register file; the file itself has one-hot write enable, one-hot tri-state read enables for buses A and B, and a shared write bus C.
- Decodes issue-stage register addresses into registered one-hot read enables.
- Keeps a busy-bit scoreboard and stalls issue on RAW and WAW hazards.
- Arbitrates the single write port between two writeback sources (WB0 = ALU, WB1 = memory) round-robin; drives write_en_all and bus_c.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/wb_rr_arbiter.sv | 30 +++
 rtl/regfile_ctrl.sv | 114 +++++++++++
 tb/tb_regfile_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared sizes, types and helpers for the register-file access controller.
package regfile_pkg;

  localparam int NUM_REGS = 32;
  localparam int AW       = 5;
  localparam int DW       = 32;

  typedef logic [AW-1:0]       reg_addr_t;
  typedef logic [NUM_REGS-1:0] reg_vec_t;

  // Decode a register address into a single-bit-set enable vector.
  function automatic reg_vec_t onehot(input reg_addr_t addr);
    reg_vec_t v;
    v       = '0;
    v[addr] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-way round-robin arbiter for the single register-file write port.
// The pointer only advances when both sides compete, so a lone requester
// never steals the other side's turn.
module wb_rr_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic ptr;  // 0: side 0 wins the next conflict, 1: side 1 wins

  // Grant the lone requester, or the pointer side when both request.
  always_comb begin
    grant = req;
    if (&req) begin
      grant = ptr ? 2'b10 : 2'b01;
    end
  end

  // Hand priority to the other side after each conflict.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= 1'b0;
    end else if (&req) begin
      ptr <= ~ptr;
    end
  end

endmodule

// File: rtl/regfile_ctrl.sv
// Register-file access controller: operand read-enable decode, busy-bit
// scoreboard with RAW/WAW issue stall, and arbitration of the write port
// between the ALU (wb0) and memory (wb1) writeback paths.
module regfile_ctrl
  import regfile_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic [AW-1:0]       issue_rs1,
  input  logic [AW-1:0]       issue_rs2,
  input  logic [AW-1:0]       issue_rd,
  input  logic                issue_rd_we,
  output logic [NUM_REGS-1:0] read_en_a_all,
  output logic [NUM_REGS-1:0] read_en_b_all,
  output logic                operand_valid,
  input  logic                wb0_valid,
  input  logic                wb1_valid,
  output logic                wb0_ready,
  output logic                wb1_ready,
  input  logic [AW-1:0]       wb0_rd,
  input  logic [AW-1:0]       wb1_rd,
  input  logic [DW-1:0]       wb0_data,
  input  logic [DW-1:0]       wb1_data,
  output logic [NUM_REGS-1:0] write_en_all,
  output logic [DW-1:0]       bus_c,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busy
);

  logic [1:0] wb_req;
  logic [1:0] wb_grant;
  logic       wb_any;
  reg_addr_t  g_rd;
  logic [DW-1:0] g_data;
  logic       accept;
  reg_vec_t   set_vec;
  reg_vec_t   clr_vec;

  assign wb_req = {wb1_valid, wb0_valid};

  wb_rr_arbiter u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (wb_req),
    .grant (wb_grant)
  );

  assign wb0_ready = wb_grant[0];
  assign wb1_ready = wb_grant[1];
  assign wb_any    = |wb_grant;

  // Steer the granted writeback onto the write port; r0 is never enabled.
  always_comb begin
    g_rd         = wb_grant[1] ? wb1_rd   : wb0_rd;
    g_data       = wb_grant[1] ? wb1_data : wb0_data;
    write_en_all = '0;
    bus_c        = '0;
    if (wb_any) begin
      bus_c = g_data;
      if (g_rd != '0) begin
        write_en_all = onehot(g_rd);
      end
    end
  end

  // Stall only on registered busy bits; a writeback clearing a register
  // this cycle is not forwarded, the issue simply waits one more cycle.
  assign issue_ready = !busy[issue_rs1] && !busy[issue_rs2] &&
                       !(issue_rd_we && busy[issue_rd]);
  assign accept      = issue_valid && issue_ready;

  // Scoreboard set/clear requests for this cycle.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (accept && issue_rd_we && (issue_rd != '0)) begin
      set_vec = onehot(issue_rd);
    end
    if (wb_any && (g_rd != '0)) begin
      clr_vec = onehot(g_rd);
    end
  end

  // Busy bits: flush wins over everything, otherwise clear then set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else if (flush) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~clr_vec) | set_vec;
    end
  end

  // One-cycle operand read enables following each accepted issue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_en_a_all <= '0;
      read_en_b_all <= '0;
      operand_valid <= 1'b0;
    end else if (accept) begin
      read_en_a_all <= onehot(issue_rs1);
      read_en_b_all <= onehot(issue_rs2);
      operand_valid <= 1'b1;
    end else begin
      read_en_a_all <= '0;
      read_en_b_all <= '0;
      operand_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Self-checking bench for regfile_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_regfile_ctrl;
  import regfile_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  logic                issue_valid;
  logic                issue_ready;
  logic [AW-1:0]       issue_rs1, issue_rs2, issue_rd;
  logic                issue_rd_we;
  logic [NUM_REGS-1:0] read_en_a_all, read_en_b_all;
  logic                operand_valid;
  logic                wb0_valid, wb1_valid, wb0_ready, wb1_ready;
  logic [AW-1:0]       wb0_rd, wb1_rd;
  logic [DW-1:0]       wb0_data, wb1_data;
  logic [NUM_REGS-1:0] write_en_all;
  logic [DW-1:0]       bus_c;
  logic                flush;
  logic [NUM_REGS-1:0] busy;

  regfile_ctrl dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
    .issue_rd_we(issue_rd_we),
    .read_en_a_all(read_en_a_all), .read_en_b_all(read_en_b_all),
    .operand_valid(operand_valid),
    .wb0_valid(wb0_valid), .wb1_valid(wb1_valid),
    .wb0_ready(wb0_ready), .wb1_ready(wb1_ready),
    .wb0_rd(wb0_rd), .wb1_rd(wb1_rd),
    .wb0_data(wb0_data), .wb1_data(wb1_data),
    .write_en_all(write_en_all), .bus_c(bus_c),
    .flush(flush), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state.
  bit [31:0] m_busy;
  int        m_ptr;     // which writeback side wins the next conflict
  bit [31:0] m_rea, m_reb;
  bit        m_ov;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic model_reset();
    m_busy = 0; m_ptr = 0; m_rea = 0; m_reb = 0; m_ov = 0;
  endtask

  task automatic idle();
    issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0; issue_rd_we = 0;
    wb0_valid = 0; wb1_valid = 0; wb0_rd = 0; wb1_rd = 0; wb0_data = 0; wb1_data = 0;
    flush = 0;
  endtask

  task automatic set_issue(input int rs1, input int rs2, input int rd, input bit we);
    issue_valid = 1; issue_rs1 = AW'(rs1); issue_rs2 = AW'(rs2);
    issue_rd = AW'(rd); issue_rd_we = we;
  endtask

  // Check one cycle against the model, advance the model across the
  // coming rising edge, and return at the following falling edge.
  task automatic cyc();
    bit rdy, acc;
    int g, grd;
    bit [31:0] exp_we, exp_c;
    #1;
    rdy = !m_busy[issue_rs1] && !m_busy[issue_rs2] && !(issue_rd_we && m_busy[issue_rd]);
    g = -1;
    if (wb0_valid && wb1_valid) g = m_ptr;
    else if (wb0_valid) g = 0;
    else if (wb1_valid) g = 1;
    grd = (g == 1) ? int'(wb1_rd) : int'(wb0_rd);
    exp_we = 0; exp_c = 0;
    if (g >= 0) begin
      exp_c = (g == 1) ? wb1_data : wb0_data;
      if (grd != 0) exp_we = 32'h1 << grd;
    end
    chk("issue_ready", {31'b0, issue_ready}, {31'b0, rdy});
    chk("wb0_ready", {31'b0, wb0_ready}, {31'b0, g == 0});
    chk("wb1_ready", {31'b0, wb1_ready}, {31'b0, g == 1});
    chk("write_en_all", write_en_all, exp_we);
    chk("bus_c", bus_c, exp_c);
    chk("busy", busy, m_busy);
    chk("read_en_a_all", read_en_a_all, m_rea);
    chk("read_en_b_all", read_en_b_all, m_reb);
    chk("operand_valid", {31'b0, operand_valid}, {31'b0, m_ov});
    acc   = issue_valid && rdy;
    m_rea = acc ? (32'h1 << issue_rs1) : 32'h0;
    m_reb = acc ? (32'h1 << issue_rs2) : 32'h0;
    m_ov  = acc;
    if (g >= 0 && grd != 0) m_busy[grd] = 1'b0;
    if (acc && issue_rd_we && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    if (flush) m_busy = 0;
    if (wb0_valid && wb1_valid) m_ptr = 1 - m_ptr;
    @(negedge clk);
  endtask

  initial begin
    idle();
    model_reset();
    reset = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 32'h0);
    chk("rst_ov", {31'b0, operand_valid}, 32'h0);
    chk("rst_rea", read_en_a_all, 32'h0);
    reset = 1;
    @(negedge clk);

    // Basic issue and decode.
    set_issue(3, 7, 5, 1); cyc();
    idle();
    chk("dec_rea", read_en_a_all, 32'h0000_0008);
    chk("dec_reb", read_en_b_all, 32'h0000_0080);
    chk("dec_ov", {31'b0, operand_valid}, 32'h1);
    chk("dec_busy", busy, 32'h0000_0020);
    cyc();

    // RAW stall released by writeback; ready only the cycle after.
    set_issue(5, 0, 6, 1);
    #1 chk("raw_stall", {31'b0, issue_ready}, 32'h0);
    cyc();
    wb0_valid = 1; wb0_rd = 5; wb0_data = 32'hDEAD_BEEF;
    #1;
    chk("raw_wen", write_en_all, 32'h0000_0020);
    chk("raw_busc", bus_c, 32'hDEAD_BEEF);
    chk("raw_nobypass", {31'b0, issue_ready}, 32'h0);
    cyc();
    wb0_valid = 0;
    #1 chk("raw_ready", {31'b0, issue_ready}, 32'h1);
    cyc();
    idle(); cyc();

    // Writeback conflict alternates WB0, WB1, WB0.
    wb0_valid = 1; wb0_rd = 1; wb0_data = 32'h1111;
    wb1_valid = 1; wb1_rd = 2; wb1_data = 32'h2222;
    #1 chk("rr0_wen", write_en_all, 32'h2); chk("rr0_g0", {31'b0, wb0_ready}, 32'h1);
    cyc();
    #1 chk("rr1_wen", write_en_all, 32'h4); chk("rr1_g1", {31'b0, wb1_ready}, 32'h1);
    cyc();
    #1 chk("rr2_wen", write_en_all, 32'h2); chk("rr2_busc", bus_c, 32'h1111);
    cyc();
    idle(); cyc();

    // r0 destination never becomes busy; its writeback has no enable.
    set_issue(0, 0, 0, 1); cyc();
    idle();
    wb1_valid = 1; wb1_rd = 0; wb1_data = 32'h1234;
    #1;
    chk("r0_ready", {31'b0, wb1_ready}, 32'h1);
    chk("r0_wen", write_en_all, 32'h0);
    chk("r0_busc", bus_c, 32'h1234);
    cyc();
    chk("r0_busy", {31'b0, busy[0]}, 32'h0);
    idle(); flush = 1; cyc();

    // Flush beats a same-cycle busy set.
    idle();
    for (int r = 4; r < 8; r++) begin set_issue(0, 0, r, 1); cyc(); end
    idle();
    chk("fl_pre", busy, 32'h0000_00F0);
    set_issue(1, 2, 9, 1); flush = 1; cyc();
    idle();
    chk("fl_busy", busy, 32'h0);
    chk("fl_ov", {31'b0, operand_valid}, 32'h1);
    cyc();

    // Asynchronous reset in the middle of operation.
    set_issue(1, 1, 3, 1); cyc();
    idle();
    reset = 0;
    #2;
    chk("ar_ov", {31'b0, operand_valid}, 32'h0);
    chk("ar_rea", read_en_a_all, 32'h0);
    chk("ar_reb", read_en_b_all, 32'h0);
    chk("ar_busy", busy, 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    set_issue(1, 2, 3, 1);
    #1 chk("ar_ready", {31'b0, issue_ready}, 32'h1);
    cyc();
    idle();
    chk("ar_rea2", read_en_a_all, 32'h2);
    chk("ar_reb2", read_en_b_all, 32'h4);
    chk("ar_busy2", busy, 32'h8);
    cyc();

    // Randomized traffic against the model, on a small register window
    // so hazards and conflicts are frequent.
    for (int i = 0; i < 3000; i++) begin
      issue_valid = 1'($urandom_range(0, 1));
      issue_rs1   = AW'($urandom_range(0, 7));
      issue_rs2   = AW'($urandom_range(0, 7));
      issue_rd    = AW'($urandom_range(0, 7));
      issue_rd_we = ($urandom_range(0, 3) != 0);
      wb0_valid   = ($urandom_range(0, 2) == 0);
      wb1_valid   = ($urandom_range(0, 2) == 0);
      wb0_rd      = AW'($urandom_range(0, 7));
      wb1_rd      = AW'($urandom_range(0, 7));
      wb0_data    = $urandom;
      wb1_data    = $urandom;
      flush       = ($urandom_range(0, 31) == 0);
      cyc();
    end
    idle(); cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
